serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Bit-serial sequencer for the 1-bit full adder (adder: a,b,cin -> sum,cout).
//   Accepts a command (tag, length, two operands, carry-in) and walks the
//   operands LSB-first through one shared adder, one bit per clock, with carry
//   held in a flop. Returns the accumulated sum, final carry and tag.
//   Sits between the command source (tb/driver) and the adder datapath.
// PARAMETERS
//   WIDTH    16  max operand width in bits (>=2)
//   LEN_W    $clog2(WIDTH+1)  width of length field
//   HDR_W    8   width of command tag
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      controller can accept a command
//   cmd_hdr    in   HDR_W  tag, returned unchanged with the result
//   cmd_len    in   LEN_W  number of bits to add, 0..WIDTH
//   cmd_a      in   WIDTH  operand A
//   cmd_b      in   WIDTH  operand B
//   cmd_cin    in   1      initial carry-in
//   rsp_valid  out  1      result present
//   rsp_ready  in   1      consumer takes result
//   rsp_hdr    out  HDR_W  tag of completed command
//   rsp_sum    out  WIDTH  sum bits [len-1:0]; bits >= len are 0
//   rsp_cout   out  1      carry out of bit len-1 (= cmd_cin when len==0)
//   busy       out  1      high in RUN
// BEHAVIOUR
//   Reset: state IDLE; cmd_ready=1; rsp_valid=0; busy=0; rsp_hdr/sum/cout=0.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready: latch hdr,a,b,len;
//     carry<=cmd_cin; idx<=0; sum<=0. len>0 -> RUN; len==0 -> DONE directly.
//     len>WIDTH is clamped to WIDTH.
//   RUN: adder.a=a[idx], adder.b=b[idx], adder.cin=carry. Each edge:
//     sum[idx]<=adder.sum; carry<=adder.cout; idx<=idx+1.
//     When idx==len-1 -> DONE. cmd_ready=0, busy=1.
//   DONE: rsp_valid=1; outputs stable until rsp_ready. On rsp_valid&rsp_ready
//     -> IDLE, rsp_valid drops next cycle. cmd_ready=0 in DONE (no overlap).
//   Latency: rsp_valid rises len edges after the accept edge (len>=1);
//     1 edge for len==0. Throughput: one command per len+2 cycles minimum.
//   Adder inputs driven 0 outside RUN; adder outputs ignored outside RUN.
//   cmd_* inputs sampled only at accept; changes during RUN/DONE ignored.
//   rsp_ready while rsp_valid=0 has no effect.
//   rst_n low mid-RUN or mid-DONE: immediate return to reset values; the
//     in-flight command is dropped, no response produced.
//   Overflow: carry beyond bit len-1 appears only on rsp_cout; never wraps
//     into rsp_sum.
// CONFIGURATION
//   SERIAL_ADD_PARITY_EN defined: extra output rsp_par (1 bit) = XOR of
//     rsp_sum[len-1:0] ^ rsp_cout, accumulated during RUN (no extra latency),
//     reset 0, valid with rsp_valid.
//   Not defined: port rsp_par and its flop absent; all else identical.
// STRUCTURE
//   Package serial_add_pkg: state enum {IDLE,RUN,DONE}; WIDTH/HDR_W defaults;
//     cmd_t struct {hdr,len,a,b,cin}; rsp_t struct {hdr,sum,cout}.
//   One sub-module: adder (existing 1-bit full adder) instantiated once as
//     u_adder; all sequencing, index counter and result register in this file.
// TESTING
//   1. hdr=8'h2A,len=2,a=2'b01,b=2'b01,cin=0 -> after 2 cycles rsp_sum=2,
//      rsp_cout=0, rsp_hdr=8'h2A.
//   2. len=16,a=16'hFFFF,b=16'h0001,cin=0 -> rsp_sum=16'h0000, rsp_cout=1,
//      rsp_valid 16 cycles after accept.
//   3. len=0,cin=1,hdr=8'h12 -> rsp_valid 1 cycle later, sum=0, cout=1.
//   4. len=4,a=16'hFFFF,b=16'hFFFF -> sum=16'h000E (upper bits 0), cout=1;
//      hold rsp_ready=0 5 cycles: outputs stable, cmd_ready=0.
//   5. rst_n pulsed low at RUN idx=3 of len=8 -> no rsp_valid; next command
//      (a=5,b=3,len=8) returns sum=8, correct tag.
//   6. Back-to-back: 20 random cmds, random rsp_ready stalls -> every result
//      equals (a+b+cin) masked to len bits, tags in order; with
//      SERIAL_ADD_PARITY_EN, rsp_par matches reference XOR.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add controller.
// Used by serial_add_ctrl and its testbench.
package serial_add_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_HDR_W = 8;
    localparam int DEF_LEN_W = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_HDR_W-1:0] hdr;
        logic [DEF_LEN_W-1:0] len;
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic                 cin;
    } cmd_t;

    typedef struct packed {
        logic [DEF_HDR_W-1:0] hdr;
        logic [DEF_WIDTH-1:0] sum;
        logic                 cout;
    } rsp_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Command/response handshake bundle for serial_add_ctrl.
// rsp_par exists only when SERIAL_ADD_PARITY_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = $clog2(WIDTH + 1),
    parameter int HDR_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [HDR_W-1:0] cmd_hdr;
    logic [LEN_W-1:0] cmd_len;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [HDR_W-1:0] rsp_hdr;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
`ifdef SERIAL_ADD_PARITY_EN
    logic             rsp_par;
`endif

    modport master (
        output cmd_valid, cmd_hdr, cmd_len, cmd_a, cmd_b, cmd_cin,
        input  cmd_ready,
        input  rsp_valid, rsp_hdr, rsp_sum, rsp_cout,
`ifdef SERIAL_ADD_PARITY_EN
        input  rsp_par,
`endif
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_hdr, cmd_len, cmd_a, cmd_b, cmd_cin,
        output cmd_ready,
        output rsp_valid, rsp_hdr, rsp_sum, rsp_cout,
`ifdef SERIAL_ADD_PARITY_EN
        output rsp_par,
`endif
        input  rsp_ready
    );

endinterface

// File: rtl/serial_add_ctrl_adder.sv
// 1-bit full adder shared by the serial sequencer.
module serial_add_ctrl_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: one operand bit per clock through u_adder.
// Define SERIAL_ADD_PARITY_EN to add the rsp_par result output.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1),
    parameter int HDR_W = DEF_HDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus,
    output logic             busy
);

    state_e           state_q;
    logic [HDR_W-1:0] hdr_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic             busy_q;

    logic [LEN_W-1:0] len_d;
    logic [WIDTH-1:0] sum_d;
    logic             run;
    logic             last;
    logic             add_a;
    logic             add_b;
    logic             add_cin;
    logic             add_sum;
    logic             add_cout;

    assign len_d = (bus.cmd_len > LEN_W'(WIDTH)) ?
                   LEN_W'(WIDTH) : bus.cmd_len;

    // Operands shift right so bit 0 is always the current bit.
    assign run     = (state_q == RUN);
    assign add_a   = run & a_q[0];
    assign add_b   = run & b_q[0];
    assign add_cin = run & carry_q;
    assign last    = (idx_q == len_q - LEN_W'(1));
    assign sum_d   = sum_q | (WIDTH'(add_sum) << idx_q);

    serial_add_ctrl_adder u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

`ifdef SERIAL_ADD_PARITY_EN
    logic par_q;
    logic par_d;

    assign par_d = par_q ^ add_sum ^ (last & add_cout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    par_q <= (len_d == '0) ? bus.cmd_cin : 1'b0;
                end
                RUN:     par_q <= par_d;
                default: par_q <= par_q;
            endcase
        end
    end

    assign bus.rsp_par = par_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hdr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        hdr_q       <= bus.cmd_hdr;
                        a_q         <= bus.cmd_a;
                        b_q         <= bus.cmd_b;
                        len_q       <= len_d;
                        carry_q     <= bus.cmd_cin;
                        idx_q       <= '0;
                        sum_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        if (len_d == '0) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= add_cout;
                    idx_q   <= idx_q + LEN_W'(1);
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    if (last) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hdr   = hdr_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = carry_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl against an arithmetic reference.
// Honours SERIAL_ADD_PARITY_EN for the rsp_par check.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int W = 16;
    localparam int L = $clog2(W + 1);
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   rsp_cnt = 0;
    rsp_t exp_q[$];

    serial_add_ctrl_if #(.WIDTH(W), .LEN_W(L), .HDR_W(H)) bus ();

    serial_add_ctrl #(.WIDTH(W), .LEN_W(L), .HDR_W(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer addition over the low len bits.
    function automatic rsp_t model(cmd_t c);
        rsp_t        r;
        int unsigned l;
        logic [32:0] full;
        logic [31:0] mask;
        l     = (c.len > W) ? W : c.len;
        mask  = (l == 0) ? 32'd0 : ((32'd1 << l) - 32'd1);
        full  = {1'b0, 32'(c.a) & mask} + {1'b0, 32'(c.b) & mask}
              + 33'(c.cin);
        r.hdr  = c.hdr;
        r.sum  = W'(full[31:0] & mask);
        r.cout = full[l];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                chk("rsp_hdr", 32'(bus.rsp_hdr), 32'(exp_q[0].hdr));
                chk("rsp_sum", 32'(bus.rsp_sum), 32'(exp_q[0].sum));
                chk("rsp_cout", 32'(bus.rsp_cout), 32'(exp_q[0].cout));
`ifdef SERIAL_ADD_PARITY_EN
                chk("rsp_par", 32'(bus.rsp_par),
                    32'((^exp_q[0].sum) ^ exp_q[0].cout));
`endif
                chk("no_overlap", 32'(bus.cmd_ready), 32'd0);
                if (bus.rsp_ready) begin
                    void'(exp_q.pop_front());
                    rsp_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [H-1:0] h, logic [L-1:0] l,
                        logic [W-1:0] a, logic [W-1:0] b, logic c);
        cmd_t cm;
        int   n = 0;
        while (!bus.cmd_ready && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("cmd_ready_timeout", 32'd1, 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_hdr   = h;
        bus.cmd_len   = l;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_cin   = c;
        cm = '{hdr: h, len: l, a: a, b: b, cin: c};
        exp_q.push_back(model(cm));
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_hdr   = H'($urandom);
        bus.cmd_len   = L'($urandom);
        bus.cmd_a     = W'($urandom);
        bus.cmd_b     = W'($urandom);
        bus.cmd_cin   = 1'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 100) begin
            step();
            lat++;
        end
        if (lat >= 100) chk("rsp_timeout", 32'd1, 32'd0);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int target;
        int cyc;
        bus.cmd_valid = 1'b0;
        bus.cmd_hdr   = '0;
        bus.cmd_len   = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
        step();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        chk("rst_rsp_hdr", 32'(bus.rsp_hdr), 32'd0);
        chk("rst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
        rst_n = 1'b1;
        step();

        send(8'h2A, L'(2), 16'h0001, 16'h0001, 1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_rsp(lat);
        chk("t1_lat", 32'(lat), 32'd2);
        chk("t1_sum", 32'(bus.rsp_sum), 32'd2);
        chk("t1_cout", 32'(bus.rsp_cout), 32'd0);
        chk("t1_hdr", 32'(bus.rsp_hdr), 32'h2A);
        consume();

        send(8'h07, L'(16), 16'hFFFF, 16'h0001, 1'b0);
        wait_rsp(lat);
        chk("t2_lat", 32'(lat), 32'd16);
        chk("t2_sum", 32'(bus.rsp_sum), 32'h0000);
        chk("t2_cout", 32'(bus.rsp_cout), 32'd1);
        consume();

        // len==0: response is visible right after the accept edge.
        send(8'h12, L'(0), 16'h1234, 16'h4321, 1'b1);
        wait_rsp(lat);
        chk("t3_lat", 32'(lat), 32'd0);
        chk("t3_sum", 32'(bus.rsp_sum), 32'd0);
        chk("t3_cout", 32'(bus.rsp_cout), 32'd1);
        chk("t3_hdr", 32'(bus.rsp_hdr), 32'h12);
        consume();

        send(8'h44, L'(4), 16'hFFFF, 16'hFFFF, 1'b0);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            chk("t4_sum", 32'(bus.rsp_sum), 32'h000E);
            chk("t4_cout", 32'(bus.rsp_cout), 32'd1);
            chk("t4_valid", 32'(bus.rsp_valid), 32'd1);
            chk("t4_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            step();
        end
        consume();
        chk("t4_valid_drop", 32'(bus.rsp_valid), 32'd0);

        send(8'h99, L'(8), 16'h00F0, 16'h000F, 1'b1);
        step();
        step();
        step();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
            step();
        end
        send(8'h5C, L'(8), 16'd5, 16'd3, 1'b0);
        wait_rsp(lat);
        chk("t5_sum", 32'(bus.rsp_sum), 32'd8);
        chk("t5_hdr", 32'(bus.rsp_hdr), 32'h5C);
        consume();

        target = rsp_cnt + 20;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send(H'(i + 8'h80), L'($urandom_range(0, 20)),
                         W'($urandom), W'($urandom), 1'($urandom));
                end
            end
            begin
                cyc = 0;
                while (rsp_cnt < target && cyc < 5000) begin
                    bus.rsp_ready = ($urandom_range(0, 2) != 0);
                    step();
                    cyc++;
                end
                bus.rsp_ready = 1'b0;
                if (cyc >= 5000) chk("rand_timeout", 32'd1, 32'd0);
            end
        join
        step();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_count", 32'(rsp_cnt), 32'(target));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
